// File: rtl/des_sbox_engine.sv
// DES S-box stage: maps a 48-bit key-mixed word through S1..S8 and evaluates LANES boxes per cycle.
// Defining DES_SBOX_PARITY_EN adds the in_par/out_par/par_err parity ports.
module des_sbox_engine #(
    parameter int unsigned LANES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
`ifdef DES_SBOX_PARITY_EN
    ,
    input  logic        in_par,
    output logic        out_par,
    output logic        par_err
`endif
);

    localparam int unsigned NCHUNK = 8 / LANES;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned RW     = LANES * 4;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {StIdle, StEval, StHold} state_e;

    // Each function returns one table row; column 0 is the most significant nibble.
    function automatic logic [63:0] s1_row(input logic [1:0] r);
        case (r)
            2'd0:    return 64'hE4D12FB83A6C5907;
            2'd1:    return 64'h0F74E2D1A6CB9538;
            2'd2:    return 64'h41E8D62BFC973A50;
            default: return 64'hFC8249175B3EA06D;
        endcase
    endfunction

    function automatic logic [63:0] s2_row(input logic [1:0] r);
        case (r)
            2'd0:    return 64'hF18E6B34972DC05A;
            2'd1:    return 64'h3D47F28EC01A69B5;
            2'd2:    return 64'h0E7BA4D158C6932F;
            default: return 64'hD8A13F42B67C05E9;
        endcase
    endfunction

    function automatic logic [63:0] s3_row(input logic [1:0] r);
        case (r)
            2'd0:    return 64'hA09E63F51DC7B428;
            2'd1:    return 64'hD709346A285ECBF1;
            2'd2:    return 64'hD6498F30B12C5AE7;
            default: return 64'h1AD069874FE3B52C;
        endcase
    endfunction

    function automatic logic [63:0] s4_row(input logic [1:0] r);
        case (r)
            2'd0:    return 64'h7DE3069A1285BC4F;
            2'd1:    return 64'hD8B56F03472C1AE9;
            2'd2:    return 64'hA690CB7DF13E5284;
            default: return 64'h3F06A1D8945BC72E;
        endcase
    endfunction

    function automatic logic [63:0] s5_row(input logic [1:0] r);
        case (r)
            2'd0:    return 64'h2C417AB6853FD0E9;
            2'd1:    return 64'hEB2C47D150FA3986;
            2'd2:    return 64'h421BAD78F9C5630E;
            default: return 64'hB8C71E2D6F09A453;
        endcase
    endfunction

    function automatic logic [63:0] s6_row(input logic [1:0] r);
        case (r)
            2'd0:    return 64'hC1AF92680D34E75B;
            2'd1:    return 64'hAF427C9561DE0B38;
            2'd2:    return 64'h9EF528C3704A1DB6;
            default: return 64'h432C95FABE17608D;
        endcase
    endfunction

    function automatic logic [63:0] s7_row(input logic [1:0] r);
        case (r)
            2'd0:    return 64'h4B2EF08D3C975A61;
            2'd1:    return 64'hD0B7491AE35C2F86;
            2'd2:    return 64'h14BDC37EAF680592;
            default: return 64'h6BD814A7950FE23C;
        endcase
    endfunction

    function automatic logic [63:0] s8_row(input logic [1:0] r);
        case (r)
            2'd0:    return 64'hD2846FB1A93E50C7;
            2'd1:    return 64'h1FD8A374C56B0E92;
            2'd2:    return 64'h7B419CE206ADF358;
            default: return 64'h21E74A8DFC90356B;
        endcase
    endfunction

    function automatic logic [3:0] sbox(input logic [2:0] box, input logic [5:0] b);
        logic [1:0]  row;
        logic [63:0] row_v;
        row = {b[5], b[0]};
        case (box)
            3'd0:    row_v = s1_row(row);
            3'd1:    row_v = s2_row(row);
            3'd2:    row_v = s3_row(row);
            3'd3:    row_v = s4_row(row);
            3'd4:    row_v = s5_row(row);
            3'd5:    row_v = s6_row(row);
            3'd6:    row_v = s7_row(row);
            default: row_v = s8_row(row);
        endcase
        return row_v[{~b[4:1], 2'b00} +: 4];
    endfunction

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [47:0]    sreg_q, sreg_d;
    logic [31:0]    acc_q, acc_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q, busy_d;
    logic [2:0]     box_base;
    logic [RW-1:0]  lane_res;

    // Lane 0 takes the top chunk, so its nibble lands in the most significant slot.
    always_comb begin
        box_base = 3'(cnt_q * LANES);
        lane_res = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            lane_res[RW-1-4*l -: 4] = sbox(box_base + 3'(l), sreg_q[47-6*l -: 6]);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        acc_d   = acc_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sreg_d  = in_data;
                    cnt_d   = '0;
                    state_d = StEval;
                end
            end
            StEval: begin
                sreg_d = sreg_q << (LANES * 6);
                acc_d  = (acc_q << RW) | 32'(lane_res);
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(NCHUNK - 1)) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StHold);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sreg_q      <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sreg_q      <= sreg_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign busy      = busy_q;

`ifdef DES_SBOX_PARITY_EN
    logic out_par_q, out_par_d;
    logic par_err_q, par_err_d;

    always_comb begin
        out_par_d = ^acc_d;
        par_err_d = par_err_q;
        if (state_q == StIdle && in_valid && ((^in_data) != in_par)) begin
            par_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_par_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            out_par_q <= out_par_d;
            par_err_q <= par_err_d;
        end
    end

    assign out_par = out_par_q;
    assign par_err = par_err_q;
`endif

    hold_stable_a: assert property (@(posedge clk) disable iff (rst)
        out_valid_q && !out_ready |=> out_valid_q && $stable(acc_q));

    valid_busy_a: assert property (@(posedge clk) disable iff (rst)
        out_valid_q |-> busy_q && !in_ready_q);

endmodule

// File: tb/tb_des_sbox_engine.sv
// Bench for des_sbox_engine: four instances (LANES 1, 2, 4, 8) share one stimulus stream, and each
// has its own scoreboard queue of expected words.
module tb_des_sbox_engine;

    localparam int NDUT = 4;

    // Flat tables: entry row*16+col, entry 0 in the top nibble.
    localparam logic [255:0] STAB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [47:0] in_data;
    logic        out_ready;
    logic        in_ready  [NDUT];
    logic        out_valid [NDUT];
    logic [31:0] out_data  [NDUT];
    logic        busy      [NDUT];
`ifdef DES_SBOX_PARITY_EN
    logic        in_par;
    logic        par_flip;
    logic        out_par   [NDUT];
    logic        par_err   [NDUT];
`endif

    int          checks;
    int          errors;
    int          cyc;
    logic [31:0] exp_word;
    logic [31:0] sb        [NDUT][$];
    bit          in_flight [NDUT];
    bit          seen_ov   [NDUT];
    bit          hold_pend [NDUT];
    logic [31:0] hold_data [NDUT];
    int          acc_cyc   [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        des_sbox_engine #(
            .LANES(1 << g)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready[g]),
            .in_data  (in_data),
            .out_valid(out_valid[g]),
            .out_ready(out_ready),
            .out_data (out_data[g]),
            .busy     (busy[g])
`ifdef DES_SBOX_PARITY_EN
            ,
            .in_par   (in_par),
            .out_par  (out_par[g]),
            .par_err  (par_err[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1);
    end

    function automatic logic [31:0] model(input logic [47:0] d);
        logic [31:0] r;
        logic [5:0]  c;
        int          idx;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            c   = d[47-6*b -: 6];
            idx = {26'd0, c[5], c[0], c[4:1]};
            r   = {r[27:0], STAB[b][255-4*idx -: 4]};
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic bit all_ready();
        for (int i = 0; i < NDUT; i++) begin
            if (!in_ready[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit any_flight();
        for (int i = 0; i < NDUT; i++) begin
            if (in_flight[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Runs with the inputs already set for the coming edge; predicts what that edge does.
    task automatic mon_step();
        logic [31:0] e;
        bit          acc;
        for (int i = 0; i < NDUT; i++) begin
            check_eq($sformatf("busy[%0d]", i), 64'(busy[i]), 64'(in_flight[i]));
            check_eq($sformatf("in_ready[%0d]", i), 64'(in_ready[i]), 64'(!in_flight[i]));
            if (!in_flight[i]) begin
                check_eq($sformatf("ov_idle[%0d]", i), 64'(out_valid[i]), 0);
            end
            acc = in_valid && in_ready[i];
            if (rst) begin
                sb[i].delete();
                in_flight[i] = 1'b0;
                seen_ov[i]   = 1'b0;
                hold_pend[i] = 1'b0;
            end else begin
                if (hold_pend[i]) begin
                    check_eq($sformatf("hold_valid[%0d]", i), 64'(out_valid[i]), 1);
                    check_eq($sformatf("hold_data[%0d]", i), 64'(out_data[i]),
                             64'(hold_data[i]));
                end
                if (out_valid[i] && !seen_ov[i]) begin
                    seen_ov[i] = 1'b1;
                    check_eq($sformatf("latency[%0d]", i), 64'(cyc - acc_cyc[i]), 64'(8 >> i));
                end
                hold_pend[i] = 1'b0;
                if (out_valid[i] && out_ready) begin
                    if (sb[i].size() == 0) begin
                        check_eq($sformatf("sb_empty[%0d]", i), 1, 0);
                    end else begin
                        e = sb[i].pop_front();
                        check_eq($sformatf("out_data[%0d]", i), 64'(out_data[i]), 64'(e));
`ifdef DES_SBOX_PARITY_EN
                        check_eq($sformatf("out_par[%0d]", i), 64'(out_par[i]), 64'(^e));
`endif
                    end
                    in_flight[i] = 1'b0;
                    seen_ov[i]   = 1'b0;
                end else if (out_valid[i]) begin
                    hold_pend[i] = 1'b1;
                    hold_data[i] = out_data[i];
                end
                if (acc) begin
                    sb[i].push_back(exp_word);
                    in_flight[i] = 1'b1;
                    acc_cyc[i]   = cyc + 1;
                end
            end
        end
    endtask

    task automatic tick();
        mon_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_input(input logic v, input logic [47:0] d, input logic [31:0] e);
        in_valid = v;
        in_data  = d;
        exp_word = e;
`ifdef DES_SBOX_PARITY_EN
        in_par   = (^d) ^ par_flip;
`endif
    endtask

    task automatic send(input logic [47:0] d, input logic [31:0] e);
        int n;
        n = 0;
        while (!all_ready() && n < 100) begin
            tick();
            n++;
        end
        check_eq("send_wait_timeout", 64'(n >= 100), 0);
        set_input(1'b1, d, e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit rand_bp);
        int n;
        n = 0;
        while (any_flight() && n < 100) begin
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        out_ready = 1'b1;
        check_eq("drain_timeout", 64'(n >= 100), 0);
    endtask

    initial begin
        logic [47:0] d;
        logic [5:0]  k6;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst       = 1'b1;
        out_ready = 1'b1;
`ifdef DES_SBOX_PARITY_EN
        par_flip  = 1'b0;
`endif
        set_input(1'b0, '0, '0);
        for (int i = 0; i < NDUT; i++) begin
            in_flight[i] = 1'b0;
            seen_ov[i]   = 1'b0;
            hold_pend[i] = 1'b0;
            hold_data[i] = '0;
            acc_cyc[i]   = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            check_eq($sformatf("rst_in_ready[%0d]", i), 64'(in_ready[i]), 1);
            check_eq($sformatf("rst_out_valid[%0d]", i), 64'(out_valid[i]), 0);
            check_eq($sformatf("rst_out_data[%0d]", i), 64'(out_data[i]), 0);
            check_eq($sformatf("rst_busy[%0d]", i), 64'(busy[i]), 0);
        end

        // Directed corner words.
        send(48'h000000000000, 32'hEFA72C4D);
        drain(1'b0);
        send(48'hFFFFFFFFFFFF, 32'hD9CE3DCB);
        drain(1'b0);

        // Backpressure; a second word offered during HOLD must wait for the return to IDLE.
        out_ready = 1'b0;
        send(48'h000000000000, 32'hEFA72C4D);
        set_input(1'b1, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB);
        repeat (12) tick();
        check_eq("bp_data_l2", 64'(out_data[1]), 64'h0EFA72C4D);
        check_eq("bp_in_ready_l2", 64'(in_ready[1]), 0);
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        drain(1'b0);

        // Reset while the LANES=1 instance evaluates with cnt=3.
        send(48'h123456789ABC, model(48'h123456789ABC));
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            check_eq($sformatf("midrst_in_ready[%0d]", i), 64'(in_ready[i]), 1);
            check_eq($sformatf("midrst_out_valid[%0d]", i), 64'(out_valid[i]), 0);
            check_eq($sformatf("midrst_out_data[%0d]", i), 64'(out_data[i]), 0);
        end
        repeat (12) tick();

        // Every index in every box at once.
        for (int k = 0; k < 64; k++) begin
            k6 = 6'(k);
            d  = {8{k6}};
            send(d, model(d));
            drain(1'b0);
        end

        // Random sweep with random backpressure.
        for (int n = 0; n < 1000; n++) begin
            d = {16'($urandom), $urandom};
            send(d, model(d));
            drain(1'b1);
        end

`ifdef DES_SBOX_PARITY_EN
        for (int i = 0; i < NDUT; i++) begin
            check_eq($sformatf("par_err_init[%0d]", i), 64'(par_err[i]), 0);
        end
        par_flip = 1'b1;
        send(48'h000000000001, model(48'h000000000001));
        par_flip = 1'b0;
        drain(1'b0);
        for (int i = 0; i < NDUT; i++) begin
            check_eq($sformatf("par_err_set[%0d]", i), 64'(par_err[i]), 1);
        end
        send(48'h000000000000, 32'hEFA72C4D);
        drain(1'b0);
        for (int i = 0; i < NDUT; i++) begin
            check_eq($sformatf("par_err_sticky[%0d]", i), 64'(par_err[i]), 1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            check_eq($sformatf("par_err_rst[%0d]", i), 64'(par_err[i]), 0);
            check_eq($sformatf("out_par_rst[%0d]", i), 64'(out_par[i]), 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
